// File: rtl/key_mem_pkg.sv
// key_mem_pkg
// Shared constants and the controller state encoding for the key_mem sequencer.
//   ADDR_WIDTH_DEF : default key_mem address width
//   DATA_WIDTH_DEF : default key word width
//   state_t        : controller states (IDLE, LOAD, PLAY, DRAIN, CLEAR)
package key_mem_pkg;

  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/key_mem_skid.sv
// key_mem_skid
// Two-entry valid/ready buffer that absorbs registered key_mem read data.
//   clk, reset       : clock, async active-high reset (empties the buffer)
//   push, push_data  : write one word (caller guarantees it never pushes when full)
//   valid, data      : head word; data is forced to 0 while empty
//   ready            : consumer accepts the head word when valid & ready
//   occupancy        : number of stored words (0..2)
module key_mem_skid
  import key_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  ready,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] slot [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  pop;

  assign valid     = (count != 2'd0);
  assign pop       = valid & ready;
  assign data      = valid ? slot[rd_ptr] : '0;
  assign occupancy = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: data is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_mem_seq.sv
// key_mem_seq
// Sequences a key_mem block: loads a key stream into addresses 0.., replays the
// stored keys cyclically with backpressure, and clears the memory on request.
//   clk, reset                  : clock, async active-high reset
//   cmd_load/play/clear/stop    : commands (load/play/clear only accepted in IDLE)
//   s_tdata/s_tvalid/s_tlast/s_tready : key load stream
//   o_tdata/o_tvalid/o_tready   : key replay stream
//   mem_*                       : all key_mem control ports (sync write, 1-cycle read)
//   key_count                   : number of stored keys
//   busy, overflow, play_err    : status
module key_mem_seq
  import key_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_load,
  input  logic                  cmd_play,
  input  logic                  cmd_clear,
  input  logic                  cmd_stop,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tvalid,
  input  logic                  o_tready,
  output logic                  mem_clear,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [ADDR_WIDTH:0]   key_count,
  output logic                  busy,
  output logic                  overflow,
  output logic                  play_err
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  overflow_r;
  logic                  play_err_r;
  logic                  read_pending;

  logic [1:0]            skid_occ;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  pop;
  logic                  room;
  logic                  last_addr;
  logic                  read_wrap;

  logic                  write_fire;
  logic                  read_fire;
  logic                  start_load;
  logic                  start_play;
  logic                  play_reject;

  assign pop       = skid_valid & o_tready;
  // A new read may issue only if its word is guaranteed a slot when it lands,
  // counting the word leaving the buffer this cycle so steady state is 1/cycle.
  assign room      = (({1'b0, skid_occ} + {2'b00, read_pending}) - {2'b00, pop}) < 3'd2;
  assign last_addr = &write_addr;
  assign read_wrap = ({1'b0, read_addr} == (count_r - (ADDR_WIDTH+1)'(1)));

  always_comb begin
    state_nxt   = state;
    s_tready    = 1'b0;
    write_fire  = 1'b0;
    read_fire   = 1'b0;
    start_load  = 1'b0;
    start_play  = 1'b0;
    play_reject = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_clear) begin
          state_nxt = ST_CLEAR;
        end else if (cmd_load) begin
          start_load = 1'b1;
          state_nxt  = ST_LOAD;
        end else if (cmd_play) begin
          if (count_r != '0) begin
            start_play = 1'b1;
            state_nxt  = ST_PLAY;
          end else begin
            play_reject = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // Stop wins over a pending beat so a dropped-ready beat is never written.
        if (cmd_stop) begin
          state_nxt = ST_IDLE;
        end else begin
          s_tready   = 1'b1;
          write_fire = s_tvalid;
          if (s_tvalid && (s_tlast || last_addr)) state_nxt = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (cmd_stop) state_nxt = ST_DRAIN;
        else          read_fire = room;
      end
      ST_DRAIN: begin
        if (skid_occ == 2'd0 && !read_pending) state_nxt = ST_IDLE;
      end
      ST_CLEAR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      write_addr   <= '0;
      read_addr    <= '0;
      count_r      <= '0;
      overflow_r   <= 1'b0;
      play_err_r   <= 1'b0;
      read_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      play_err_r   <= play_reject;
      read_pending <= read_fire;
      if (start_load) begin
        write_addr <= '0;
        count_r    <= '0;
        overflow_r <= 1'b0;
      end
      if (write_fire) begin
        write_addr <= write_addr + ADDR_WIDTH'(1);
        count_r    <= count_r + (ADDR_WIDTH+1)'(1);
        if (last_addr && !s_tlast) overflow_r <= 1'b1;
      end
      if (start_play) read_addr <= '0;
      if (read_fire) read_addr <= read_wrap ? '0 : read_addr + ADDR_WIDTH'(1);
      if (state == ST_CLEAR) begin
        count_r    <= '0;
        overflow_r <= 1'b0;
      end
    end
  end

  key_mem_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (read_pending),
    .push_data (mem_read_data),
    .valid     (skid_valid),
    .data      (skid_data),
    .ready     (o_tready),
    .occupancy (skid_occ)
  );

  assign o_tvalid         = skid_valid;
  assign o_tdata          = skid_data;
  assign mem_clear        = (state == ST_CLEAR);
  assign mem_write_enable = write_fire;
  assign mem_write_addr   = write_addr;
  assign mem_write_data   = write_fire ? s_tdata : '0;
  assign mem_read_enable  = read_fire;
  assign mem_read_addr    = read_addr;
  assign key_count        = count_r;
  assign busy             = (state != ST_IDLE);
  assign overflow         = overflow_r;
  assign play_err         = play_err_r;

endmodule

// File: doc/key_mem_seq.md
Name: key_mem_seq

Overview:
- Controller that sequences the key_mem storage block (ADDR_WIDTH x DATA_WIDTH, sync write, 1-cycle registered read).
- Loads a key sequence from an AXI-Stream-style input into consecutive addresses from 0.
- Replays the stored sequence cyclically on an output stream with full backpressure.
- Owns every key_mem control port (clear, read_enable, write_enable, addresses, write_data) and sits between host key-load logic and the consumer datapath.

Parameters:
- ADDR_WIDTH, 10: key_mem address width; capacity DEPTH = 2^ADDR_WIDTH.
- DATA_WIDTH, 32: key word width.

Ports:
- clk  in  1  single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- cmd_load  in  1  pulse; starts LOAD from IDLE.
- cmd_play  in  1  pulse; starts PLAY from IDLE.
- cmd_clear  in  1  pulse; starts CLEAR from IDLE.
- cmd_stop  in  1  level/pulse; ends LOAD or PLAY.
- s_tdata  in  DATA_WIDTH  load data.
- s_tvalid  in  1  load data valid.
- s_tlast  in  1  last load word.
- s_tready  out  1  load ready.
- o_tdata  out  DATA_WIDTH  replay data.
- o_tvalid  out  1  replay valid.
- o_tready  in  1  replay ready.
- mem_clear  out  1  key_mem clear.
- mem_write_enable  out  1  key_mem write strobe.
- mem_write_addr  out  ADDR_WIDTH  key_mem write address.
- mem_write_data  out  DATA_WIDTH  key_mem write data.
- mem_read_enable  out  1  key_mem read strobe.
- mem_read_addr  out  ADDR_WIDTH  key_mem read address.
- mem_read_data  in  DATA_WIDTH  key_mem read data, valid 1 cycle after mem_read_enable.
- key_count  out  ADDR_WIDTH+1  number of stored keys.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky: load hit DEPTH without tlast.
- play_err  out  1  one-cycle pulse: cmd_play with key_count == 0.

Behaviour:
- Reset (async): state = IDLE; every output 0; key_count = 0; overflow = 0; read/write addresses = 0; skid buffer emptied. Reset mid-operation aborts immediately with no further memory strobes.
- FSM states: IDLE, LOAD, PLAY, DRAIN, CLEAR.
- Command priority in IDLE: clear > load > play. Commands arriving outside IDLE are ignored.
- IDLE -> LOAD:
  - write_addr = 0, key_count = 0.
  - s_tready = 1 in LOAD only.
  - Each s_tvalid & s_tready drives mem_write_enable = 1 combinationally with mem_write_addr = write_addr and mem_write_data = s_tdata; then write_addr++ and key_count++.
- Exit LOAD -> IDLE after the beat with s_tlast, or after the beat at write_addr == DEPTH-1.
  - If that final beat lacks tlast: overflow = 1 (sticky until next cmd_load or reset). Writes never wrap.
  - cmd_stop in LOAD: -> IDLE with no write that cycle; key_count keeps the completed beats.
- IDLE -> PLAY: requires key_count > 0; otherwise play_err pulses and state stays IDLE. On entry read_addr = 0.
- PLAY reads:
  - mem_read_enable asserts when (skid occupancy + reads in flight) < 2.
  - read_addr wraps to 0 after key_count-1.
  - Returned data enters a 2-entry skid buffer.
  - o_tvalid = buffer non-empty; a transfer happens on o_tvalid & o_tready.
  - Throughput is 1 word/cycle when o_tready is held high.
  - First o_tvalid arrives 2 cycles after entering PLAY.
- cmd_stop in PLAY -> DRAIN: no new reads; in-flight and buffered words are still delivered; -> IDLE when the buffer is empty and no read is pending. No word is ever dropped or duplicated.
- CLEAR: mem_clear = 1 for exactly one cycle; key_count = 0, overflow = 0; -> IDLE next cycle.
- mem_write_enable and mem_read_enable are never asserted in the same cycle.
- mem_clear is never asserted together with either enable.

Decomposition:
- Package key_mem_pkg: state encoding localparams (IDLE=0, LOAD=1, PLAY=2, DRAIN=3, CLEAR=4), default ADDR_WIDTH/DATA_WIDTH constants.
- Sub-module key_mem_skid: 2-entry valid/ready buffer with occupancy output, parameterized by DATA_WIDTH.
- Top level holds the FSM, the counters and a key_mem instance in the bench only.

Test Plan:
- Load 512 words, data 2000, 2004, ... (step 4), s_tlast on word 512 -> key_count = 512, overflow = 0, mem address 511 holds 4044.
- Load 1024 words with no s_tlast -> exits LOAD after address 1023, key_count = 1024, overflow = 1, no write to address 0 after the first.
- After a 4-word load (2000..2012), cmd_play with o_tready = 1 for 10 beats -> o_tdata 2000, 2004, 2008, 2012, 2000, ... with wrap and no bubbles after the first valid.
- Play with o_tready toggled randomly 50%, then cmd_stop -> output sequence is gapless modulo 4, DRAIN delivers all pending words, busy drops, and no word is lost or repeated.
- cmd_play right after reset -> play_err pulses once, busy stays 0. Then cmd_clear after a load -> one-cycle mem_clear, key_count = 0.
- Assert reset during PLAY with 2 words buffered -> all outputs 0 asynchronously; after release state is IDLE and key_count = 0.
